// File: rtl/tiled_mm_controller_if.sv
// Memory-side bus of the tiled controller: ib/wb/ob SRAM strobes and the PE array control planes.
interface tiled_mm_controller_if #(
    parameter int ROW    = 4,
    parameter int COL    = 4,
    parameter int W_SIZE = 256,
    parameter int I_SIZE = 256,
    parameter int O_SIZE = 256
);
    logic                        wb_mem_cenb_o;
    logic                        wb_mem_wenb_o;
    logic [$clog2(W_SIZE)-1:0]   wb_mem_addr_o;
    logic                        ib_mem_cenb_o;
    logic                        ib_mem_wenb_o;
    logic [$clog2(I_SIZE)-1:0]   ib_mem_addr_o;
    logic                        ob_mem_cenb_o;
    logic                        ob_mem_wenb_o;
    logic [$clog2(O_SIZE)-1:0]   ob_mem_addr_o;
    logic                        ob_acc_o;
    logic [0:ROW-1][0:COL-1]     ctrl_load_o;
    logic [0:ROW-1][0:COL-1]     ctrl_sum_out_o;
    logic [0:ROW-1][0:COL-1]     ctrl_ps_in_o;
    logic [0:ROW-1][0:COL-1]     ctrl_ps_valid_o;

    modport master (
        output wb_mem_cenb_o, wb_mem_wenb_o, wb_mem_addr_o,
        output ib_mem_cenb_o, ib_mem_wenb_o, ib_mem_addr_o,
        output ob_mem_cenb_o, ob_mem_wenb_o, ob_mem_addr_o, ob_acc_o,
        output ctrl_load_o, ctrl_sum_out_o, ctrl_ps_in_o, ctrl_ps_valid_o
    );

    modport slave (
        input wb_mem_cenb_o, wb_mem_wenb_o, wb_mem_addr_o,
        input ib_mem_cenb_o, ib_mem_wenb_o, ib_mem_addr_o,
        input ob_mem_cenb_o, ob_mem_wenb_o, ob_mem_addr_o, ob_acc_o,
        input ctrl_load_o, ctrl_sum_out_o, ctrl_ps_in_o, ctrl_ps_valid_o
    );
endinterface

// File: rtl/tiled_mm_controller.sv
// K-tiled sequencer for the weight-stationary systolic array: reloads weights per tile,
// streams inputs and tags every output write after the first tile for accumulation.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start_i; illegal config pulses error_o
// S_LOAD    | ROW weight reads, then one ctrl_load_o cycle (c = 0..ROW)
// S_COMPUTE | input reads c < i_rows, output writes PIPE_LAT <= c
// S_DONE    | one-cycle done_o pulse
module tiled_mm_controller #(
    parameter int WIDTH     = 8,
    parameter int ROW       = 4,
    parameter int COL       = 4,
    parameter int W_SIZE    = 256,
    parameter int I_SIZE    = 256,
    parameter int O_SIZE    = 256,
    parameter int MAX_TILES = 16,
    parameter int PIPE_LAT  = ROW + COL
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [$clog2(I_SIZE):0]       cfg_i_rows_i,
    input  logic [$clog2(MAX_TILES):0]    cfg_n_tiles_i,
    input  logic [$clog2(W_SIZE)-1:0]     cfg_w_offset_i,
    input  logic [$clog2(I_SIZE)-1:0]     cfg_i_offset_i,
    input  logic [$clog2(O_SIZE)-1:0]     cfg_o_offset_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    tiled_mm_controller_if.master         bus
);
    localparam int WAW = $clog2(W_SIZE);
    localparam int IAW = $clog2(I_SIZE);
    localparam int OAW = $clog2(O_SIZE);
    localparam int IRW = $clog2(I_SIZE) + 1;
    localparam int TW  = $clog2(MAX_TILES) + 1;
    localparam int CW  = IRW + 1;

    // The compute counter must reach i_rows + PIPE_LAT - 1 for the widest i_rows.
    if (WIDTH < 1 || PIPE_LAT < 1 || PIPE_LAT >= (1 << IRW)) begin : g_bad_params
        $error("tiled_mm_controller: WIDTH/PIPE_LAT out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_t;

    state_t          st, st_n;
    logic [CW-1:0]   c, c_n;
    logic [TW-1:0]   t, t_n;
    logic [IRW-1:0]  i_rows_q, i_rows_n;
    logic [TW-1:0]   n_tiles_q, n_tiles_n;
    logic [WAW-1:0]  w_off_q, w_off_n;
    logic [IAW-1:0]  i_off_q, i_off_n;
    logic [OAW-1:0]  o_off_q, o_off_n;
    logic            err_n, cfg_bad, c_last;

    logic                    wb_cenb_d, ib_cenb_d, ob_cenb_d, acc_d;
    logic [WAW-1:0]          wb_addr_d;
    logic [IAW-1:0]          ib_addr_d;
    logic [OAW-1:0]          ob_addr_d;
    logic [0:ROW-1][0:COL-1] load_d, sum_d, pv_d;

    assign cfg_bad = (cfg_i_rows_i == '0) || (cfg_n_tiles_i == '0) ||
                     (int'(cfg_n_tiles_i) > MAX_TILES);
    assign c_last  = (int'(c) == int'(i_rows_q) + PIPE_LAT - 1);

    always_comb begin
        st_n      = st;
        c_n       = c;
        t_n       = t;
        i_rows_n  = i_rows_q;
        n_tiles_n = n_tiles_q;
        w_off_n   = w_off_q;
        i_off_n   = i_off_q;
        o_off_n   = o_off_q;
        err_n     = 1'b0;
        if (abort_i) begin
            st_n = S_IDLE;
            c_n  = '0;
            t_n  = '0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (start_i) begin
                        if (cfg_bad) begin
                            err_n = 1'b1;
                        end else begin
                            i_rows_n  = cfg_i_rows_i;
                            n_tiles_n = cfg_n_tiles_i;
                            w_off_n   = cfg_w_offset_i;
                            i_off_n   = cfg_i_offset_i;
                            o_off_n   = cfg_o_offset_i;
                            c_n       = '0;
                            t_n       = '0;
                            st_n      = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (int'(c) == ROW) begin
                        st_n = S_COMPUTE;
                        c_n  = '0;
                    end else begin
                        c_n = c + CW'(1);
                    end
                end
                S_COMPUTE: begin
                    if (c_last) begin
                        c_n = '0;
                        if (int'(t) + 1 < int'(n_tiles_q)) begin
                            t_n  = t + TW'(1);
                            st_n = S_LOAD;
                        end else begin
                            st_n = S_DONE;
                        end
                    end else begin
                        c_n = c + CW'(1);
                    end
                end
                default: begin
                    st_n = S_IDLE;
                    c_n  = '0;
                end
            endcase
        end
    end

    // Outputs decode the upcoming state/counter so they line up with the cycle the state is held.
    always_comb begin
        wb_cenb_d = 1'b1;
        wb_addr_d = '0;
        ib_cenb_d = 1'b1;
        ib_addr_d = '0;
        ob_cenb_d = 1'b1;
        ob_addr_d = '0;
        acc_d     = 1'b0;
        load_d    = '0;
        sum_d     = '1;
        pv_d      = '0;
        case (st_n)
            S_LOAD: begin
                sum_d = '0;
                if (int'(c_n) < ROW) begin
                    wb_cenb_d = 1'b0;
                    wb_addr_d = w_off_n + WAW'(int'(t_n) * ROW) + WAW'(c_n);
                end else begin
                    load_d = '1;
                end
            end
            S_COMPUTE: begin
                if (int'(c_n) < int'(i_rows_n)) begin
                    ib_cenb_d = 1'b0;
                    ib_addr_d = i_off_n + IAW'(int'(t_n) * int'(i_rows_n)) + IAW'(c_n);
                end
                if (int'(c_n) >= PIPE_LAT) begin
                    ob_cenb_d = 1'b0;
                    ob_addr_d = o_off_n + OAW'(int'(c_n) - PIPE_LAT);
                    acc_d     = (t_n != '0);
                end
                for (int r = 0; r < ROW; r++) begin
                    if (int'(c_n) >= r && int'(c_n) < int'(i_rows_n) + r) pv_d[r] = '1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            st                  <= S_IDLE;
            c                   <= '0;
            t                   <= '0;
            i_rows_q            <= '0;
            n_tiles_q           <= '0;
            w_off_q             <= '0;
            i_off_q             <= '0;
            o_off_q             <= '0;
            busy_o              <= 1'b0;
            done_o              <= 1'b0;
            error_o             <= 1'b0;
            bus.wb_mem_cenb_o   <= 1'b1;
            bus.wb_mem_addr_o   <= '0;
            bus.ib_mem_cenb_o   <= 1'b1;
            bus.ib_mem_addr_o   <= '0;
            bus.ob_mem_cenb_o   <= 1'b1;
            bus.ob_mem_wenb_o   <= 1'b1;
            bus.ob_mem_addr_o   <= '0;
            bus.ob_acc_o        <= 1'b0;
            bus.ctrl_load_o     <= '0;
            bus.ctrl_sum_out_o  <= '1;
            bus.ctrl_ps_valid_o <= '0;
        end else begin
            st                  <= st_n;
            c                   <= c_n;
            t                   <= t_n;
            i_rows_q            <= i_rows_n;
            n_tiles_q           <= n_tiles_n;
            w_off_q             <= w_off_n;
            i_off_q             <= i_off_n;
            o_off_q             <= o_off_n;
            busy_o              <= (st_n == S_LOAD) || (st_n == S_COMPUTE);
            done_o              <= (st_n == S_DONE);
            error_o             <= err_n;
            bus.wb_mem_cenb_o   <= wb_cenb_d;
            bus.wb_mem_addr_o   <= wb_addr_d;
            bus.ib_mem_cenb_o   <= ib_cenb_d;
            bus.ib_mem_addr_o   <= ib_addr_d;
            bus.ob_mem_cenb_o   <= ob_cenb_d;
            bus.ob_mem_wenb_o   <= ob_cenb_d;
            bus.ob_mem_addr_o   <= ob_addr_d;
            bus.ob_acc_o        <= acc_d;
            bus.ctrl_load_o     <= load_d;
            bus.ctrl_sum_out_o  <= sum_d;
            bus.ctrl_ps_valid_o <= pv_d;
        end
    end

    assign bus.wb_mem_wenb_o = 1'b1;
    assign bus.ib_mem_wenb_o = 1'b1;

    // Partial sums enter only at the top row; never changes at run time.
    always_comb begin
        bus.ctrl_ps_in_o    = '0;
        bus.ctrl_ps_in_o[0] = '1;
    end
endmodule

// File: doc/tiled_mm_controller.md
Name: tiled_mm_controller

Overview:
- Next-generation memory-mode control path for the weight-stationary systolic array.
- Sequences K-dimension tiling. Reduction depth exceeds ROW, so weights are reloaded once per tile.
- Inputs are streamed per tile.
- Output-buffer writes are tagged for accumulation on every tile after the first.
- Adds abort, busy/error status and a configurable pipeline latency. Sits between the top-level config registers and the ib/wb/ob SRAMs plus the PE array.

Parameters:
- WIDTH, 8, data element width (pass-through only)
- ROW, 4, PE array rows (weight rows per tile)
- COL, 4, PE array columns
- W_SIZE, 256, weight buffer depth
- I_SIZE, 256, input buffer depth
- O_SIZE, 256, output buffer depth
- MAX_TILES, 16, maximum number of K tiles
- PIPE_LAT, ROW+COL, cycles from input read issue to matching output write

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, synchronous, active-low
- start_i  in  1  start request, sampled only in IDLE
- abort_i  in  1  abort, highest priority
- cfg_i_rows_i  in  $clog2(I_SIZE)+1  input rows per tile
- cfg_n_tiles_i  in  $clog2(MAX_TILES)+1  number of K tiles
- cfg_w_offset_i  in  $clog2(W_SIZE)  weight base address
- cfg_i_offset_i  in  $clog2(I_SIZE)  input base address
- cfg_o_offset_i  in  $clog2(O_SIZE)  output base address
- busy_o  out  1  high in LOAD/COMPUTE
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  one-cycle pulse on illegal config at start
- wb_mem_cenb_o, wb_mem_wenb_o  out  1 each  weight SRAM enable/write, active-low
- wb_mem_addr_o  out  $clog2(W_SIZE)  weight address
- ib_mem_cenb_o, ib_mem_wenb_o  out  1 each  input SRAM enable/write, active-low
- ib_mem_addr_o  out  $clog2(I_SIZE)  input address
- ob_mem_cenb_o, ob_mem_wenb_o  out  1 each  output SRAM enable/write, active-low
- ob_mem_addr_o  out  $clog2(O_SIZE)  output address
- ob_acc_o  out  1  write must accumulate into the stored value
- ctrl_load_o, ctrl_sum_out_o, ctrl_ps_in_o, ctrl_ps_valid_o  out  [0:ROW-1][0:COL-1] each  PE controls

Behaviour:
- Reset (rstn_i low at a clk_i edge):
  - State goes to IDLE; tile and cycle counters go to 0.
  - All cenb/wenb go to 1 and all addresses go to 0.
  - busy_o, done_o, error_o, ob_acc_o go to 0.
  - ctrl_load_o, ctrl_ps_valid_o go to '0; ctrl_sum_out_o goes to '1.
  - ctrl_ps_in_o row 0 = '1, other rows '0; this value is constant outside reset.
  - Reset mid-operation behaves identically; wenb is never left low.
- Outputs are registered and decoded from next state/counter, so they are valid in the same cycle the state is occupied.
- IDLE:
  - If start_i is high and cfg_i_rows_i==0 or cfg_n_tiles_i==0 or cfg_n_tiles_i>MAX_TILES: pulse error_o and stay in IDLE.
  - Otherwise latch all cfg_* values, set tile t=0, go to LOAD.
  - start_i outside IDLE is ignored.
- LOAD (ROW+1 cycles, counter c=0..ROW):
  - For c<ROW: wb_mem_cenb_o=0, wb_mem_addr_o = w_offset + t*ROW + c.
  - ctrl_sum_out_o='0 throughout (weights flow south).
  - At c==ROW: ctrl_load_o='1 for exactly that cycle.
  - Then go to COMPUTE with c reset to 0.
- COMPUTE (i_rows+PIPE_LAT cycles):
  - Read: for c<i_rows, ib_mem_cenb_o=0, ib_mem_addr_o = i_offset + t*i_rows + c.
  - Write: for PIPE_LAT<=c<i_rows+PIPE_LAT, ob_mem_cenb_o=0, ob_mem_wenb_o=0, ob_mem_addr_o = o_offset + (c-PIPE_LAT), ob_acc_o=(t!=0).
  - ctrl_ps_valid_o row r = '1 while r<=c<i_rows+r, else '0 (diagonal wavefront).
  - Reads and writes overlap whenever i_rows>PIPE_LAT.
  - At the last cycle: if t<n_tiles-1, increment t and go to LOAD; otherwise go to DONE.
- DONE (1 cycle): done_o=1, then go to IDLE.
- abort_i high at any edge: go to IDLE next cycle. All enables are deasserted, busy_o=0, and no done_o pulse is issued.
- All address arithmetic wraps modulo the address width.
- All wenb outputs other than ob_mem_wenb_o are held at 1.

Test Plan:
- Single tile: ROW=COL=4, PIPE_LAT=8, i_rows=3, offsets 0.
  - Start sampled at edge 0 -> LOAD cycles 1-5: wb addr 0..3, ctrl_load_o at cycle 5.
  - COMPUTE cycles 6-16: ib addr 0..2 at cycles 6-8; ob writes addr 0..2 at cycles 14-16 with ob_acc_o=0.
  - done_o at cycle 17.
- Two tiles, i_rows=3, w_offset=16, i_offset=32:
  - Tile 1 wb addr 20..23, ib addr 35..37; its ob writes have ob_acc_o=1.
  - done_o at cycle 33.
- Illegal config: start with cfg_n_tiles_i=0 -> error_o pulses 1 cycle, busy_o stays 0, no memory enable asserted.
- Abort in COMPUTE cycle 10 -> IDLE next cycle, all cenb=1, no done_o; a subsequent start runs normally.
- Address wrap and overlap: o_offset=254, i_rows=12 -> ob addr 254, 255, 0..9; reads and writes are concurrent for c=8..11.
- Sync reset asserted mid-LOAD -> all outputs at reset values after that edge; start_i held high during reset has no effect.
